// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit (0), DATA_W data bits MSB first, STOP_BITS stop bits (1).
// Every bit lasts BIT_DIV clk cycles; the line idles high.
module serial_frame_tx #(
    parameter int DATA_W    = 5,
    parameter int BIT_DIV   = 500,
    parameter int STOP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_line
);

    localparam int CW = $clog2(BIT_DIV + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int SW = $clog2(STOP_BITS + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [SW-1:0]     stop_q, stop_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              line_q, line_d;
    logic              done_q, done_d;

    logic              wrap;
    logic [DATA_W-1:0] shift_next;

    assign wrap       = (cnt_q == CNT_LAST);
    assign shift_next = shift_q << 1;

    // line_d is the value for the state being entered, so tx_line stays registered
    always_comb begin
        state_d = state_q;
        cnt_d   = wrap ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        line_d  = line_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                line_d = 1'b1;
                if (tx_valid) begin
                    shift_d = tx_data;
                    state_d = S_START;
                    line_d  = 1'b0;
                end
            end
            S_START: begin
                if (wrap) begin
                    state_d = S_DATA;
                    bit_d   = BIT_LAST;
                    line_d  = shift_q[DATA_W-1];
                end
            end
            S_DATA: begin
                if (wrap) begin
                    if (bit_q == '0) begin
                        state_d = S_STOP;
                        stop_d  = '0;
                        line_d  = 1'b1;
                    end else begin
                        shift_d = shift_next;
                        bit_d   = bit_q - BW'(1);
                        line_d  = shift_next[DATA_W-1];
                    end
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = stop_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= '0;
            shift_q <= '0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_done  = done_q;
    assign tx_line  = line_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx with BIT_DIV=4, STOP_BITS=2, DATA_W=5 (32-cycle frames).
module tb_serial_frame_tx;

    logic       clk;
    logic       rst_n;
    logic       tx_valid;
    logic [4:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_line;

    int n_cmp = 0;
    int n_bad = 0;

    serial_frame_tx #(
        .DATA_W   (5),
        .BIT_DIV  (4),
        .STOP_BITS(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_valid(tx_valid),
        .tx_data (tx_data),
        .tx_ready(tx_ready),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx_line (tx_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent receiver: detects the start edge and samples each bit at its centre
    logic       rx_act;
    int         rx_cnt;
    logic [4:0] rx_sh;
    logic [4:0] rx_word;
    int         rx_frames;

    always @(posedge clk) begin
        if (!rst_n) begin
            rx_act <= 1'b0;
            rx_cnt <= 0;
        end else if (!rx_act) begin
            if (tx_line == 1'b0) begin
                rx_act <= 1'b1;
                rx_cnt <= 1;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 6 && rx_cnt <= 22 && ((rx_cnt - 2) % 4) == 0)
                rx_sh <= {rx_sh[3:0], tx_line};
            if (rx_cnt == 26) begin
                rx_act    <= 1'b0;
                rx_word   <= rx_sh;
                rx_frames <= rx_frames + 1;
            end
        end
    end

    typedef struct {
        logic [4:0] data;
        logic [7:0] frame;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for idle, present the word, return #1 after the accept edge.
    task automatic accept(input logic [4:0] d);
        int waited = 0;
        while (!tx_ready && waited < 100) begin
            step();
            waited++;
        end
        if (!tx_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        tx_valid = 1'b1;
        tx_data  = d;
        step();
        tx_valid = 1'b0;
    endtask

    // Checks 32 frame cycles starting at the current sample, then the tx_done cycle.
    // At poke_k a stray word is presented for one cycle.
    task automatic watch_frame(input logic [7:0] frame, input int poke_k, input string nm);
        logic [7:0] f;
        f = frame;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) step();
            if (k == poke_k) begin
                tx_valid = 1'b1;
                tx_data  = 5'b11111;
            end
            if (k == poke_k + 1) tx_valid = 1'b0;
            chk($sformatf("%s_line_k%0d", nm, k), tx_line, f[7 - k / 4]);
            chk($sformatf("%s_ready_k%0d", nm, k), tx_ready, 0);
            chk($sformatf("%s_busy_k%0d", nm, k), tx_busy, 1);
            chk($sformatf("%s_done_k%0d", nm, k), tx_done, 0);
        end
        step();
        chk({nm, "_done_pulse"}, tx_done, 1);
        chk({nm, "_ready_end"}, tx_ready, 1);
        chk({nm, "_busy_end"}, tx_busy, 0);
        chk({nm, "_line_end"}, tx_line, 1);
    endtask

    initial begin
        int rx_before;

        vecs[0] = '{data: 5'b10110, frame: 8'b0_10110_11};
        vecs[1] = '{data: 5'b00000, frame: 8'b0_00000_11};
        vecs[2] = '{data: 5'b11111, frame: 8'b0_11111_11};
        vecs[3] = '{data: 5'b01101, frame: 8'b0_01101_11};

        rst_n     = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        rx_frames = 0;
        rx_sh     = '0;
        rx_word   = '0;

        // Reset held 3 cycles, then 20 idle cycles
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("rst_line", tx_line, 1);
            chk("rst_ready", tx_ready, 1);
            chk("rst_busy", tx_busy, 0);
            chk("rst_done", tx_done, 0);
            step();
        end

        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            accept(vecs[v].data);
            watch_frame(vecs[v].frame, -10, $sformatf("vec%0d", v));
            step();
            chk($sformatf("vec%0d_done_clear", v), tx_done, 0);
            repeat (3) step();
        end

        // Back-to-back: valid held, word changed after the first accept
        tx_valid = 1'b1;
        tx_data  = 5'b00001;
        step();
        tx_data = 5'b11111;
        watch_frame(8'b0_00001_11, -10, "b2b_a");
        step();
        tx_valid = 1'b0;
        chk("b2b_second_start", tx_line, 0);
        watch_frame(8'b0_11111_11, -10, "b2b_b");
        step();
        chk("b2b_done_clear", tx_done, 0);

        // Data change and stray valid during DATA are ignored
        accept(5'b01010);
        watch_frame(8'b0_01010_11, 9, "ign");
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ign_no_second_done", tx_done, 0);
            chk("ign_stays_ready", tx_ready, 1);
            chk("ign_line_idle", tx_line, 1);
        end

        // Reset during the third data bit drops the frame
        accept(5'b10110);
        for (int k = 1; k <= 13; k++) step();
        chk("rst_mid_line_before", tx_line, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_mid_line", tx_line, 1);
        chk("rst_mid_ready", tx_ready, 1);
        chk("rst_mid_busy", tx_busy, 0);
        chk("rst_mid_done", tx_done, 0);
        for (int i = 0; i < 40; i++) begin
            step();
            chk("rst_mid_no_done", tx_done, 0);
            chk("rst_mid_idle_line", tx_line, 1);
        end
        accept(5'b11001);
        watch_frame(8'b0_11001_11, -10, "post_rst");
        step();

        // Loopback into the receiver model
        repeat (4) step();
        rx_before = rx_frames;
        accept(5'b10011);
        watch_frame(8'b0_10011_11, -10, "loop");
        chk("loop_rx_frames", rx_frames - rx_before, 1);
        chk("loop_rx_word", {27'd0, rx_word}, {27'd0, 5'b10011});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
